// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one request at a time, word-addressed memory port with byte lanes.
// Latency: ACCESS LAT+1 cycles after accept, response one cycle later; errors/no-ops respond next cycle.
// Backpressure: response held with stable data until out_ready; in_ready low while busy.
module ysyx_23060111_lsu #(
  parameter int unsigned LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [2:0]  in_func,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [31:0] m_raddr,
  output logic        m_ren,
  input  logic [31:0] m_rdata,
  output logic [31:0] m_waddr,
  output logic [31:0] m_wdata,
  output logic [31:0] m_wmask,
  output logic        m_wen
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  // Counter start value: LAT-1 so that WAIT lasts exactly LAT cycles.
  localparam logic [3:0] CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  state_t      state_q;
  state_t      state_d;

  logic        ren_q;
  logic        wen_q;
  logic [2:0]  func_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic        req_noop;
  logic [1:0]  off;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_result;

  // Decode errors on the incoming request so the decision is made at the accept edge.
  always_comb begin
    req_err  = 1'b0;
    req_noop = !in_ren && !in_wen;
    if (in_ren && in_wen) begin
      req_err = 1'b1;
    end else if (in_ren) begin
      case (in_func)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = in_addr[0];
        3'b010:         req_err = (in_addr[1:0] != 2'b00);
        default:        req_err = 1'b1;
      endcase
    end else if (in_wen) begin
      case (in_func)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = in_addr[0];
        3'b010:  req_err = (in_addr[1:0] != 2'b00);
        default: req_err = 1'b1;
      endcase
    end
  end

  // State register; reset aborts any in-flight request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/strobe outputs, all from registered state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    m_ren     = 1'b0;
    m_wen     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (req_err || req_noop) begin
            state_d = S_RESP;
          end else if (LAT == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        m_ren   = ren_q;
        m_wen   = wen_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture at accept; the wait counter counts down while in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      func_q  <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 4'd0;
    end else if (state_q == S_IDLE && in_valid) begin
      ren_q   <= in_ren;
      wen_q   <= in_wen;
      func_q  <= in_func;
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
      cnt_q   <= CNT_INIT;
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Response registers: cleared on accept, load result captured at the end of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (state_q == S_IDLE && in_valid) begin
      rdata_q <= 32'h0;
      err_q   <= req_err;
    end else if (state_q == S_ACCESS && ren_q) begin
      rdata_q <= ld_result;
    end
  end

  assign off = addr_q[1:0];

  // Store lane placement: mask and data shifted into the addressed byte lanes.
  always_comb begin
    st_mask = 4'b0000;
    st_data = 32'h0;
    case (func_q[1:0])
      2'b00: begin
        st_mask = 4'b0001 << off;
        st_data = 32'(wdata_q[7:0]) << {off, 3'b000};
      end
      2'b01: begin
        st_mask = 4'b0011 << {addr_q[1], 1'b0};
        st_data = 32'(wdata_q[15:0]) << {addr_q[1], 4'b0000};
      end
      2'b10: begin
        st_mask = 4'b1111;
        st_data = wdata_q;
      end
      default: begin
        st_mask = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  // Load extraction from the returned word with sign or zero extension.
  always_comb begin
    rd_byte   = 8'(m_rdata >> {off, 3'b000});
    rd_half   = 16'(m_rdata >> {addr_q[1], 4'b0000});
    ld_result = 32'h0;
    case (func_q)
      3'b000:  ld_result = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_result = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_result = m_rdata;
      3'b100:  ld_result = {24'h0, rd_byte};
      3'b101:  ld_result = {16'h0, rd_half};
      default: ld_result = 32'h0;
    endcase
  end

  assign m_raddr   = {addr_q[31:2], 2'b00};
  assign m_waddr   = {addr_q[31:2], 2'b00};
  assign m_wdata   = st_data;
  assign m_wmask   = {28'h0, (m_wen ? st_mask : 4'b0000)};
  assign out_rdata = rdata_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Bench for the load/store unit: instance 0 with LAT=0, instance 1 with LAT=3, each with a small memory.
// Latency: response and memory-access cycles are checked against the accept cycle.
// Backpressure: out_ready is withheld on the LAT=3 instance to check hold behaviour.
module tb_ysyx_23060111_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          vcyc;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  logic        clk = 1'b0;
  logic        mem_init;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        rst       [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        in_ren    [2];
  logic        in_wen    [2];
  logic [2:0]  in_func   [2];
  logic [31:0] in_addr   [2];
  logic [31:0] in_wdata  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_rdata [2];
  logic        out_err   [2];
  logic [31:0] m_raddr   [2];
  logic        m_ren     [2];
  logic [31:0] m_rdata   [2];
  logic [31:0] m_waddr   [2];
  logic [31:0] m_wdata   [2];
  logic [31:0] m_wmask   [2];
  logic        m_wen     [2];

  resp_t rq [2][$];
  acc_t  aq [2][$];
  logic  pv [2];

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge is the number of posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [64];

    ysyx_23060111_lsu #(.LAT((g == 0) ? 0 : 3)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_ren    (in_ren[g]),
      .in_wen    (in_wen[g]),
      .in_func   (in_func[g]),
      .in_addr   (in_addr[g]),
      .in_wdata  (in_wdata[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_rdata (out_rdata[g]),
      .out_err   (out_err[g]),
      .m_raddr   (m_raddr[g]),
      .m_ren     (m_ren[g]),
      .m_rdata   (m_rdata[g]),
      .m_waddr   (m_waddr[g]),
      .m_wdata   (m_wdata[g]),
      .m_wmask   (m_wmask[g]),
      .m_wen     (m_wen[g])
    );

    // Memory model: combinational read, byte-masked write on the clock edge.
    always @(posedge clk) begin
      if (mem_init) begin
        for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
        mem[1] <= 32'hCAFE8765;
        mem[4] <= 32'h11223344;
      end else if (m_wen[g]) begin
        for (int b = 0; b < 4; b++)
          if (m_wmask[g][b]) mem[m_waddr[g][7:2]][8*b +: 8] <= m_wdata[g][8*b +: 8];
      end
    end

    assign m_rdata[g] = mem[m_raddr[g][7:2]];
  end

  function automatic int lat_of(int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic chk(bit ok, string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  // Monitor: compares responses and memory accesses against the scoreboard queues.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i] !== 1'b0) begin
        pv[i] = 1'b0;
      end else begin
        if (out_valid[i]) begin
          if (rq[i].size() == 0) begin
            chk(1'b0, "unexpected_resp", i, out_rdata[i], 32'h0);
          end else begin
            chk(out_rdata[i] == rq[i][0].rdata, "rdata", i, out_rdata[i], rq[i][0].rdata);
            chk(out_err[i] == rq[i][0].err, "err", i, 32'(out_err[i]), 32'(rq[i][0].err));
            chk(in_ready[i] == 1'b0, "in_ready_busy", i, 32'(in_ready[i]), 32'h0);
            if (!pv[i])
              chk(cyc == rq[i][0].vcyc, "valid_cycle", i, cyc, rq[i][0].vcyc);
            if (out_ready[i]) void'(rq[i].pop_front());
          end
        end
        pv[i] = out_valid[i];
        if (m_ren[i] || m_wen[i]) begin
          if (aq[i].size() == 0) begin
            chk(1'b0, "unexpected_access", i, 32'(m_wen[i]), 32'h0);
          end else begin
            acc_t a;
            a = aq[i].pop_front();
            chk(m_wen[i] == a.wr, "access_kind", i, 32'(m_wen[i]), 32'(a.wr));
            chk(m_ren[i] == !a.wr, "access_ren", i, 32'(m_ren[i]), 32'(!a.wr));
            chk(cyc == a.cyc, "access_cycle", i, cyc, a.cyc);
            if (a.wr) begin
              chk(m_waddr[i] == a.addr, "waddr", i, m_waddr[i], a.addr);
              chk(m_wmask[i] == {28'h0, a.mask}, "wmask", i, m_wmask[i], {28'h0, a.mask});
              chk(m_wdata[i] == a.data, "wdata", i, m_wdata[i], a.data);
            end else begin
              chk(m_raddr[i] == a.addr, "raddr", i, m_raddr[i], a.addr);
              chk(m_wmask[i] == 32'h0, "wmask_on_read", i, m_wmask[i], 32'h0);
            end
          end
        end
      end
    end
  end

  // Drive one request; push its expected response/access unless track is clear.
  task automatic issue(int i, bit ren, bit wen, bit [2:0] func, bit [31:0] addr,
                       bit [31:0] wdata, bit [31:0] rdata_e, bit err_e,
                       bit acc, bit [3:0] mask_e, bit [31:0] mdata_e, bit track);
    int    n;
    int    st;
    resp_t r;
    acc_t  a;
    in_valid[i] = 1'b1;
    in_ren[i]   = ren;
    in_wen[i]   = wen;
    in_func[i]  = func;
    in_addr[i]  = addr;
    in_wdata[i] = wdata;
    n = 0;
    while (!in_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[i]) begin
      chk(1'b0, "accept_timeout", i, 32'h0, 32'h1);
      in_valid[i] = 1'b0;
      return;
    end
    st = cyc;
    if (track) begin
      r.rdata = rdata_e;
      r.err   = err_e;
      r.vcyc  = (err_e || (!ren && !wen)) ? st + 1 : st + 2 + lat_of(i);
      rq[i].push_back(r);
      if (acc) begin
        a.wr   = wen;
        a.addr = {addr[31:2], 2'b00};
        a.mask = mask_e;
        a.data = mdata_e;
        a.cyc  = st + 1 + lat_of(i);
        aq[i].push_back(a);
      end
    end
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_done(int i);
    int n;
    n = 0;
    while ((rq[i].size() != 0 || aq[i].size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(rq[i].size() == 0 && aq[i].size() == 0, "drain_timeout", i,
        32'(rq[i].size() + aq[i].size()), 32'h0);
  endtask

  task automatic chk_reset(int i);
    chk(in_ready[i] == 1'b1, "rst_in_ready", i, 32'(in_ready[i]), 32'h1);
    chk(out_valid[i] == 1'b0, "rst_out_valid", i, 32'(out_valid[i]), 32'h0);
    chk(out_rdata[i] == 32'h0, "rst_out_rdata", i, out_rdata[i], 32'h0);
    chk(out_err[i] == 1'b0, "rst_out_err", i, 32'(out_err[i]), 32'h0);
    chk(m_ren[i] == 1'b0 && m_wen[i] == 1'b0, "rst_m_en", i, {30'h0, m_ren[i], m_wen[i]}, 32'h0);
    chk(m_wmask[i] == 32'h0, "rst_m_wmask", i, m_wmask[i], 32'h0);
    chk(m_raddr[i] == 32'h0 && m_waddr[i] == 32'h0, "rst_m_addr", i, m_raddr[i] | m_waddr[i], 32'h0);
    chk(m_wdata[i] == 32'h0, "rst_m_wdata", i, m_wdata[i], 32'h0);
  endtask

  initial begin
    int n;
    mem_init = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      in_valid[i]  = 1'b0;
      in_ren[i]    = 1'b0;
      in_wen[i]    = 1'b0;
      in_func[i]   = 3'b000;
      in_addr[i]   = 32'h0;
      in_wdata[i]  = 32'h0;
      out_ready[i] = 1'b1;
      pv[i]        = 1'b0;
    end
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);

    // LAT=0 directed vectors: ren wen func addr wdata | rdata err acc mask mdata
    issue(0, 0, 1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0,        0, 1, 4'hF, 32'hDEADBEEF, 1);
    issue(0, 1, 0, 3'b010, 32'h80000004, 32'h0,        32'hDEADBEEF, 0, 1, 4'h0, 32'h0, 1);
    issue(0, 0, 1, 3'b000, 32'h80000011, 32'h000000A5, 32'h0,        0, 1, 4'h2, 32'h0000A500, 1);
    issue(0, 1, 0, 3'b000, 32'h80000011, 32'h0,        32'hFFFFFFA5, 0, 1, 4'h0, 32'h0, 1);
    issue(0, 1, 0, 3'b100, 32'h80000011, 32'h0,        32'h000000A5, 0, 1, 4'h0, 32'h0, 1);
    issue(0, 1, 0, 3'b010, 32'h80000010, 32'h0,        32'h1122A544, 0, 1, 4'h0, 32'h0, 1);
    issue(0, 1, 0, 3'b001, 32'h80000012, 32'h0,        32'h00001122, 0, 1, 4'h0, 32'h0, 1);
    issue(0, 1, 0, 3'b000, 32'h80000013, 32'h0,        32'h00000011, 0, 1, 4'h0, 32'h0, 1);
    issue(0, 0, 1, 3'b001, 32'h80000022, 32'h00008001, 32'h0,        0, 1, 4'hC, 32'h80010000, 1);
    issue(0, 1, 0, 3'b001, 32'h80000022, 32'h0,        32'hFFFF8001, 0, 1, 4'h0, 32'h0, 1);
    issue(0, 1, 0, 3'b101, 32'h80000022, 32'h0,        32'h00008001, 0, 1, 4'h0, 32'h0, 1);
    // Errors and no-op: no memory access, response in cycle 1.
    issue(0, 1, 0, 3'b010, 32'h80000002, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0, 1);
    issue(0, 1, 1, 3'b010, 32'h80000004, 32'h12345678, 32'h0,        1, 0, 4'h0, 32'h0, 1);
    issue(0, 1, 0, 3'b011, 32'h80000004, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0, 1);
    issue(0, 0, 1, 3'b100, 32'h80000004, 32'h55555555, 32'h0,        1, 0, 4'h0, 32'h0, 1);
    issue(0, 0, 1, 3'b001, 32'h80000021, 32'h0000FFFF, 32'h0,        1, 0, 4'h0, 32'h0, 1);
    issue(0, 0, 1, 3'b010, 32'h80000006, 32'hFFFFFFFF, 32'h0,        1, 0, 4'h0, 32'h0, 1);
    issue(0, 0, 0, 3'b010, 32'h80000004, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0, 1);
    // Erroring SW must not have written: word 1 still holds the earlier store.
    issue(0, 1, 0, 3'b010, 32'h80000004, 32'h0,        32'hDEADBEEF, 0, 1, 4'h0, 32'h0, 1);
    wait_done(0);

    // LAT=3 with backpressure: hold out_ready low for 5 cycles once the response appears.
    out_ready[1] = 1'b0;
    issue(1, 1, 0, 3'b001, 32'h80000006, 32'h0, 32'hFFFFCAFE, 0, 1, 4'h0, 32'h0, 1);
    n = 0;
    while (!out_valid[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(out_valid[1] == 1'b1, "bp_valid_timeout", 1, 32'(out_valid[1]), 32'h1);
    repeat (5) @(negedge clk);
    out_ready[1] = 1'b1;
    wait_done(1);

    issue(1, 0, 1, 3'b000, 32'h80000007, 32'h0000007F, 32'h0,        0, 1, 4'h8, 32'h7F000000, 1);
    issue(1, 1, 0, 3'b010, 32'h80000004, 32'h0,        32'h7FFE8765, 0, 1, 4'h0, 32'h0, 1);
    issue(1, 1, 0, 3'b010, 32'h80000006, 32'h0,        32'h0,        1, 0, 4'h0, 32'h0, 1);
    wait_done(1);

    // Reset while a store sits in WAIT: no write pulse, outputs back to reset values.
    issue(1, 0, 1, 3'b010, 32'h80000008, 32'h12345678, 32'h0, 0, 0, 4'h0, 32'h0, 0);
    rst[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk(m_wen[1] == 1'b0, "abort_m_wen", 1, 32'(m_wen[1]), 32'h0);
      @(negedge clk);
    end
    rst[1] = 1'b0;
    chk_reset(1);
    @(negedge clk);
    issue(1, 1, 0, 3'b010, 32'h80000008, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 1);
    wait_done(1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
